fetch_ctrl: RTL and testbench
=============================

// Module: fetch_ctrl
// PURPOSE
//  Instruction-fetch sequencer for the 5-stage ARM pipeline. Owns the PC, drives
//  the instruction-memory request/address, absorbs variable memory latency, and
//  loads the IF/ID pipeline register. Honours freeze (hazard unit) and
//  branch_taken/branch_addr (EXE). The combinational ROM is supported with
//  imem_ready tied 1.
// PARAMETERS
//  RESET_PC  32'h0  PC value loaded on reset.
//  PC_STEP   4      Sequential PC increment, in bytes.
// PORTS
//  clk           in   1   Rising-edge clock; the only clock.
//  rst           in   1   Synchronous, active-high reset.
//  freeze        in   1   Hold PC and IF/ID (load-use hazard).
//  branch_taken  in   1   Redirect fetch; flush IF/ID.
//  branch_addr   in   32  Branch target; bits [1:0] ignored (forced 0).
//  imem_req      out  1   Fetch request valid.
//  imem_addr     out  32  Fetch address (= PC).
//  imem_rdata    in   32  Instruction returned by memory.
//  imem_ready    in   1   imem_rdata valid for the current imem_addr this cycle.
//  if_valid      out  1   IF/ID holds a real instruction.
//  if_pc         out  32  PC+4 of the held instruction (ARM convention).
//  if_instr      out  32  Held instruction word.
//  fetch_cnt     out  32  Perf: instructions delivered (see CONFIGURATION).
//  bubble_cnt    out  32  Perf: bubble cycles inserted (see CONFIGURATION).
// BEHAVIOUR
//  - Reset (any cycle, including mid-wait or in HOLD): pc=RESET_PC, state=IDLE,
//    imem_req=0, if_valid=0, if_pc=0, if_instr=0, hold buffer cleared,
//    counters=0. Any in-flight response is discarded.
//  - States:
//    - IDLE: a single cycle after reset, then REQ.
//    - REQ: imem_req=1.
//    - HOLD: imem_req=0; a fetched word is parked in the hold buffer.
//  - imem_addr = pc in every state.
//  - Priority per edge: rst > branch_taken > freeze > normal.
//  - branch_taken (any state):
//    - pc <= {branch_addr[31:2],2'b0}; if_valid <= 0; hold buffer dropped.
//    - State -> REQ. A same-cycle imem_ready response is discarded.
//  - REQ, imem_ready=1, freeze=0:
//    - if_instr <= imem_rdata; if_pc <= pc+PC_STEP; if_valid <= 1; pc <= pc+PC_STEP.
//    - Latency: address cycle N -> IF/ID valid after edge ending cycle N.
//    - With imem_ready tied 1: one instruction per cycle.
//  - REQ, imem_ready=0, freeze=0: pc holds; if_valid <= 0 (bubble).
//  - REQ, imem_ready=1, freeze=1: IF/ID holds; rdata parked in hold buffer;
//    state -> HOLD; pc holds.
//  - REQ, imem_ready=0, freeze=1: everything holds; stay in REQ.
//  - HOLD, freeze=1: everything holds.
//  - HOLD, freeze=0: buffer -> IF/ID (if_valid=1, if_pc=pc+PC_STEP);
//    pc <= pc+PC_STEP; state -> REQ.
//  - PC arithmetic is modulo 2^32: 32'hFFFFFFFC + 4 wraps to 0.
//  - imem_ready while imem_req=0 is ignored.
// CONFIGURATION
//  - IF_PERF_CNT_EN defined:
//    - fetch_cnt increments on every edge that sets if_valid=1 from a new word.
//    - bubble_cnt increments on every edge that clears if_valid for a
//      wait or a flush.
//    - Both counters wrap at 2^32.
//  - IF_PERF_CNT_EN undefined: both ports exist and are tied to 0; no counter
//    flops are built.
// TESTING
//  1. rst 1 cycle, imem_ready=1, ROM words W0..W3 -> IDLE one cycle, then
//     if_pc=4,8,12,16 on consecutive cycles with if_instr=W0..W3, if_valid=1.
//  2. imem_ready low 3 cycles at pc=8 -> if_valid=0 for 3 cycles, pc stays 8,
//     then if_instr=MEM[8], if_pc=12; bubble_cnt=3 (perf build).
//  3. freeze=1 for 2 cycles while a response arrives at pc=12 -> if_pc holds 12
//     (instr @8); HOLD, imem_req=0; on release if_pc=16 with MEM[12]; nothing lost.
//  4. branch_taken=1, branch_addr=32'h0000_0093, with freeze=1 and imem_ready=1
//     -> pc=0x90, if_valid=0 next cycle, then if_pc=0x94.
//  5. rst asserted in HOLD -> next cycle pc=RESET_PC, if_valid=0, buffer empty,
//     counters 0.
//  6. Branch to 32'hFFFF_FFFC, imem_ready=1 -> if_pc=0 (wrap); next fetch at pc=0.

Source files
------------

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer for the 5-stage ARM pipeline.
// Owns the PC, issues instruction-memory requests, absorbs variable memory
// latency and loads the IF/ID register. A word that arrives while the hazard
// unit freezes the pipe is parked in a one-entry hold buffer, so it is not lost.
// Optional feature macro: IF_PERF_CNT_EN (builds the performance counters).
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   i_freeze        hold PC and IF/ID
//   i_branch_taken  redirect fetch to i_branch_addr (bits [1:0] ignored), flush IF/ID
//   o_imem_req      fetch request valid
//   o_imem_addr     fetch address (= PC)
//   i_imem_rdata    returned instruction
//   i_imem_ready    i_imem_rdata valid for o_imem_addr this cycle
//   o_if_valid      IF/ID holds a real instruction
//   o_if_pc         PC+4 of the held instruction
//   o_if_instr      held instruction word
//   o_fetch_cnt     instructions delivered (0 without IF_PERF_CNT_EN)
//   o_bubble_cnt    bubble cycles inserted (0 without IF_PERF_CNT_EN)
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_freeze,
    input  logic        i_branch_taken,
    input  logic [31:0] i_branch_addr,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_imem_ready,
    output logic        o_if_valid,
    output logic [31:0] o_if_pc,
    output logic [31:0] o_if_instr,
    output logic [31:0] o_fetch_cnt,
    output logic [31:0] o_bubble_cnt
);
    typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;
    state_t      r_state, w_state_n;
    logic [31:0] r_pc, w_pc_n;
    logic [31:0] r_if_pc, w_if_pc_n;
    logic [31:0] r_if_instr, w_if_instr_n;
    logic [31:0] r_hold, w_hold_n;
    logic        r_if_valid, w_if_valid_n;
    logic [31:0] w_pc_inc;
    assign w_pc_inc    = r_pc + PC_STEP;
    assign o_imem_req  = (r_state == REQ);
    assign o_imem_addr = r_pc;
    assign o_if_valid  = r_if_valid;
    assign o_if_pc     = r_if_pc;
    assign o_if_instr  = r_if_instr;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_pc       <= RESET_PC;
            r_if_valid <= 1'b0;
            r_if_pc    <= '0;
            r_if_instr <= '0;
            r_hold     <= '0;
        end else begin
            r_state    <= w_state_n;
            r_pc       <= w_pc_n;
            r_if_valid <= w_if_valid_n;
            r_if_pc    <= w_if_pc_n;
            r_if_instr <= w_if_instr_n;
            r_hold     <= w_hold_n;
        end
    end
    always_comb begin
        w_state_n    = r_state;
        w_pc_n       = r_pc;
        w_if_valid_n = r_if_valid;
        w_if_pc_n    = r_if_pc;
        w_if_instr_n = r_if_instr;
        w_hold_n     = r_hold;
        if (i_branch_taken) begin
            // masking rather than slicing keeps every target bit referenced
            w_pc_n       = i_branch_addr & ~32'h3;
            w_if_valid_n = 1'b0;
            w_hold_n     = '0;
            w_state_n    = REQ;
        end else if (r_state == IDLE) begin
            w_state_n = REQ;
        end else if (r_state == HOLD) begin
            if (!i_freeze) begin
                w_if_valid_n = 1'b1;
                w_if_pc_n    = w_pc_inc;
                w_if_instr_n = r_hold;
                w_pc_n       = w_pc_inc;
                w_state_n    = REQ;
            end
        end else if (i_imem_ready) begin
            if (i_freeze) begin
                w_hold_n  = i_imem_rdata;
                w_state_n = HOLD;
            end else begin
                w_if_valid_n = 1'b1;
                w_if_pc_n    = w_pc_inc;
                w_if_instr_n = i_imem_rdata;
                w_pc_n       = w_pc_inc;
            end
        end else if (!i_freeze) begin
            w_if_valid_n = 1'b0;
        end
    end
`ifdef IF_PERF_CNT_EN
    logic        w_fetch, w_bubble;
    logic [31:0] r_fetch_cnt, r_bubble_cnt;
    // a delivered word comes either straight from memory or from the hold buffer
    assign w_fetch  = !i_branch_taken && !i_freeze &&
                      ((r_state == REQ && i_imem_ready) || r_state == HOLD);
    assign w_bubble = i_branch_taken || (!i_freeze && r_state == REQ && !i_imem_ready);
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            r_fetch_cnt  <= r_fetch_cnt + {31'd0, w_fetch};
            r_bubble_cnt <= r_bubble_cnt + {31'd0, w_bubble};
        end
    end
    assign o_fetch_cnt  = r_fetch_cnt;
    assign o_bubble_cnt = r_bubble_cnt;
`else
    assign o_fetch_cnt  = '0;
    assign o_bubble_cnt = '0;
`endif
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed and random checks of fetch_ctrl against a behavioural model.
module tb_fetch_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        freeze = 1'b0;
    logic        br = 1'b0;
    logic [31:0] baddr = '0;
    logic        rdy = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr, imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc, if_instr, fetch_cnt, bubble_cnt;
    int          total = 0;
    int          bad = 0;

    // reference model: where fetching is, what IF/ID shows, what is parked
    logic [31:0] m_pc = '0, m_if_pc = '0, m_instr = '0, m_park_word = '0;
    logic        m_valid = 1'b0, m_starting = 1'b1, m_parked = 1'b0;
    logic [31:0] m_fc = '0, m_bc = '0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    assign imem_rdata = mem(imem_addr);

    fetch_ctrl dut (
        .clk(clk), .rst(rst), .i_freeze(freeze), .i_branch_taken(br),
        .i_branch_addr(baddr), .o_imem_req(imem_req), .o_imem_addr(imem_addr),
        .i_imem_rdata(imem_rdata), .i_imem_ready(rdy), .o_if_valid(if_valid),
        .o_if_pc(if_pc), .o_if_instr(if_instr), .o_fetch_cnt(fetch_cnt),
        .o_bubble_cnt(bubble_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        if (rst) begin
            m_pc = '0; m_valid = 1'b0; m_if_pc = '0; m_instr = '0;
            m_starting = 1'b1; m_parked = 1'b0; m_fc = '0; m_bc = '0;
        end else if (br) begin
            m_pc = {baddr[31:2], 2'b00};
            m_valid = 1'b0; m_parked = 1'b0; m_starting = 1'b0; m_bc++;
        end else if (m_starting) begin
            m_starting = 1'b0;
        end else if (m_parked) begin
            if (!freeze) begin
                m_valid = 1'b1; m_instr = m_park_word; m_if_pc = m_pc + 4;
                m_pc = m_pc + 4; m_parked = 1'b0; m_fc++;
            end
        end else if (freeze) begin
            if (rdy) begin
                m_parked = 1'b1; m_park_word = mem(m_pc);
            end
        end else if (rdy) begin
            m_valid = 1'b1; m_instr = mem(m_pc); m_if_pc = m_pc + 4;
            m_pc = m_pc + 4; m_fc++;
        end else begin
            m_valid = 1'b0; m_bc++;
        end
    endtask

    task automatic check_all();
        chk("imem_req", {31'd0, imem_req}, {31'd0, !(m_starting || m_parked)});
        chk("imem_addr", imem_addr, m_pc);
        chk("if_valid", {31'd0, if_valid}, {31'd0, m_valid});
        chk("if_pc", if_pc, m_if_pc);
        chk("if_instr", if_instr, m_instr);
`ifdef IF_PERF_CNT_EN
        chk("fetch_cnt", fetch_cnt, m_fc);
        chk("bubble_cnt", bubble_cnt, m_bc);
`else
        chk("fetch_cnt", fetch_cnt, 32'd0);
        chk("bubble_cnt", bubble_cnt, 32'd0);
`endif
    endtask

    task automatic cyc(input logic r, input logic b, input logic [31:0] a,
                       input logic f, input logic y);
        rst = r; br = b; baddr = a; freeze = f; rdy = y;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
        @(negedge clk);
    endtask

    initial begin
        // reset, IDLE, then four back-to-back fetches
        cyc(1, 0, 0, 0, 1);
        chk("rst_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_addr", imem_addr, 32'd0);
        cyc(0, 0, 0, 0, 1);
        chk("idle_no_valid", {31'd0, if_valid}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            cyc(0, 0, 0, 0, 1);
            chk("seq_if_pc", if_pc, 32'(4 * (k + 1)));
            chk("seq_instr", if_instr, mem(32'(4 * k)));
        end
        // memory wait of three cycles at pc=8
        cyc(0, 1, 32'd8, 0, 1);
        for (int k = 0; k < 3; k++) begin
            cyc(0, 0, 0, 0, 0);
            chk("wait_addr", imem_addr, 32'd8);
        end
        cyc(0, 0, 0, 0, 1);
        chk("wait_if_pc", if_pc, 32'd12);
        chk("wait_instr", if_instr, mem(32'd8));
        // freeze while the response for pc=12 arrives
        cyc(0, 0, 0, 1, 1);
        chk("frz_req", {31'd0, imem_req}, 32'd0);
        chk("frz_if_pc", if_pc, 32'd12);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0);
        chk("rel_if_pc", if_pc, 32'd16);
        chk("rel_instr", if_instr, mem(32'd12));
        // branch wins over freeze and a same-cycle response
        cyc(0, 1, 32'h0000_0093, 1, 1);
        chk("br_addr", imem_addr, 32'h90);
        cyc(0, 0, 0, 0, 1);
        chk("br_if_pc", if_pc, 32'h94);
        // reset while holding a parked word
        cyc(0, 0, 0, 1, 1);
        cyc(1, 0, 0, 1, 1);
        chk("hold_rst_valid", {31'd0, if_valid}, 32'd0);
        cyc(0, 0, 0, 0, 1);
        // wrap-around at the top of the address space
        cyc(0, 1, 32'hFFFF_FFFC, 0, 1);
        cyc(0, 0, 0, 0, 1);
        chk("wrap_if_pc", if_pc, 32'd0);
        chk("wrap_addr", imem_addr, 32'd0);
        // random traffic
        for (int k = 0; k < 400; k++) begin
            cyc($urandom_range(0, 49) == 0, $urandom_range(0, 9) == 0, $urandom,
                $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
